tail_light_seq: RTL
===================

// Module: tail_light_seq
// PURPOSE
//  Parametrised tail-light sequencer: N lamps per side, sequential turn indication,
//  hazard flashing and brake overlay. Sits between the driver switch inputs and the
//  board LED pins. Generates its own step tick from the system clock.
// PARAMETERS
//  LAMPS     3         lamps per side, 1..8; lamp 0 is innermost (lights first)
//  TICK_DIV  50000000  clocks per sequencer step, >=1 (1 = step every clock, for sim)
// PORTS
//  Clk     in   1      system clock; all logic on posedge Clk
//  Rst     in   1      synchronous, active-high reset
//  Left    in   1      left-turn request (level, pre-synchronised)
//  Right   in   1      right-turn request (level)
//  Hazard  in   1      hazard request (level)
//  Brake   in   1      brake pedal (level)
//  L       out  LAMPS  left lamps, bit k = lamp k
//  R       out  LAMPS  right lamps
// BEHAVIOUR
//  Reset: Rst=1 at posedge -> state IDLE, step=0, divider=0; L=R=0 while Rst=1,
//   regardless of Brake. Rst has priority over every other event.
//  Tick: divider counts 0..TICK_DIV-1; tick=1 in the cycle where count==TICK_DIV-1;
//   count wraps to 0 on the same edge. First tick after reset release occurs
//   TICK_DIV clocks later. The state register updates only on edges where tick=1.
//   Inputs are sampled only at those edges; toggles between ticks are ignored.
//  States: IDLE, LSEQ(step 1..LAMPS), RSEQ(step 1..LAMPS), HAZ_ON, HAZ_OFF.
//  Hazard condition HZ = Hazard | (Left & Right). At a tick, evaluate in this order:
//   - HZ from IDLE/LSEQ/RSEQ/HAZ_OFF -> HAZ_ON; HZ from HAZ_ON -> HAZ_OFF.
//   - !HZ from HAZ_ON or HAZ_OFF -> IDLE.
//   - IDLE: Left -> LSEQ step 1; Right -> RSEQ step 1; otherwise stay IDLE.
//   - LSEQ step k: Left & !Right & k<LAMPS -> step k+1; step LAMPS -> IDLE;
//     Left dropped or Right asserted -> IDLE. RSEQ mirrors this.
//   - Held request therefore cycles 1..LAMPS, IDLE, 1.. (period LAMPS+1 ticks).
//  Outputs (Moore, decoded from registered state, valid the cycle after the tick edge):
//   - IDLE: L=R=0.
//   - LSEQ k: L = (1<<k)-1, R = 0. RSEQ mirrors this.
//   - HAZ_ON: L=R=all ones. HAZ_OFF: L=R=0.
//  Brake overlay (combinational on decoded outputs, never alters state):
//   - IDLE: L=R=all ones. LSEQ: R=all ones. RSEQ: L=all ones.
//   - In HAZ_ON/HAZ_OFF, Brake is ignored.
//  Illegal state encoding -> IDLE at the next clock edge, not the next tick.
//  Outputs are never X after reset; the step counter width is $clog2(LAMPS+1).
// STRUCTURE
//  tail_light_pkg: state encoding localparams (IDLE, LSEQ, RSEQ, HAZ_ON, HAZ_OFF)
//   and the LAMPS_MAX=8 constant. Parameter range is checked at elaboration.
//  Sub-module tick_gen #(TICK_DIV): (Clk, Rst) -> tick; a one-cycle pulse.
//  Top level holds the state/step registers, next-state logic and output decode
//   with the brake overlay.
// TESTING (LAMPS=3, TICK_DIV=4 unless noted)
//  1 Rst=1 for 3 clk with Brake=1 -> L=R=000 throughout; release -> first tick
//    4 clk later; with Brake=1 and Rst=0, IDLE shows L=R=111.
//  2 Left=1 held for 5 ticks -> L=001,011,111,000,001 on successive ticks; R=000.
//  3 Right held for 2 ticks then dropped -> R=001,011, then 000 at the next tick;
//    toggling Right between ticks has no effect.
//  4 Left=Right=1, Brake=1 -> L=R=111,000,111 per tick; drop both -> IDLE at next tick.
//  5 Brake=1 during a Left sequence -> R=111 constant, L=001,011,111, then L=111 in IDLE.
//  6 Rst pulsed mid-sequence at LSEQ step 2 -> L=000 next edge; divider restarts,
//    with the next tick 4 clk after release; repeat with TICK_DIV=1 and LAMPS=1.

Source files
------------

// File: rtl/tail_light_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Package : tail_light_pkg
//  Brief   : State encoding and shared limits for the tail-light sequencer.
//  Rev     : 1.0  initial release
// ============================================================================
package tail_light_pkg;

    localparam int LAMPS_MAX = 8;

    typedef logic [2:0] state_t;

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LSEQ    = 3'd1;
    localparam logic [2:0] RSEQ    = 3'd2;
    localparam logic [2:0] HAZ_ON  = 3'd3;
    localparam logic [2:0] HAZ_OFF = 3'd4;

    function automatic logic state_encoding_legal(input state_t s);
        return (s <= HAZ_OFF);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tail_light_seq_if.sv
`default_nettype none
// ============================================================================
//  Interface : tail_light_seq_if
//  Brief     : Switch inputs and lamp outputs of the tail-light sequencer.
//  Rev       : 1.0  initial release
// ============================================================================
interface tail_light_seq_if #(
    parameter int LAMPS = 3
);
    logic             Left;
    logic             Right;
    logic             Hazard;
    logic             Brake;
    logic [LAMPS-1:0] L;
    logic [LAMPS-1:0] R;

    modport master (output Left, Right, Hazard, Brake, input  L, R);
    modport slave  (input  Left, Right, Hazard, Brake, output L, R);
endinterface
`default_nettype wire

// File: rtl/tail_light_seq_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module : tick_gen
//  Brief  : One-cycle step pulse every TICK_DIV clocks, restarted by reset.
//  Rev    : 1.0  initial release
// ============================================================================
module tick_gen #(
    parameter int TICK_DIV = 50000000
) (
    input  logic Clk,
    input  logic Rst,
    output logic tick_o
);

    generate
        if (TICK_DIV <= 1) begin : g_every_clock
            assign tick_o = 1'b1;
        end else begin : g_divider
            localparam int            CW   = $clog2(TICK_DIV);
            localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

            logic [CW-1:0] count_q;

            always_ff @(posedge Clk) begin
                if (Rst || count_q == LAST) begin
                    count_q <= '0;
                end else begin
                    count_q <= count_q + CW'(1);
                end
            end

            assign tick_o = (count_q == LAST);
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/tail_light_seq.sv
`default_nettype none
// ============================================================================
//  Module : tail_light_seq
//  Brief  : Sequential turn, hazard and brake tail-light controller.
//  Rev    : 1.0  initial release
// ============================================================================
module tail_light_seq
    import tail_light_pkg::*;
#(
    parameter int LAMPS    = 3,
    parameter int TICK_DIV = 50000000
) (
    input  logic             Clk,
    input  logic             Rst,
    tail_light_seq_if.slave  bus
);

    localparam int            SW       = $clog2(LAMPS + 1);
    localparam logic [SW-1:0] STEP_MAX = SW'(LAMPS);

    generate
        if (LAMPS < 1 || LAMPS > LAMPS_MAX || TICK_DIV < 1) begin : g_bad_param
            $error("tail_light_seq: LAMPS must be 1..%0d and TICK_DIV >= 1", LAMPS_MAX);
        end
    endgenerate

    logic             tick;
    logic             hz;
    logic             legal;
    state_t           state_q, state_d;
    logic [SW-1:0]    step_q,  step_d;
    logic [LAMPS-1:0] bar;
    logic [LAMPS-1:0] l_dec, r_dec;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .Clk    (Clk),
        .Rst    (Rst),
        .tick_o (tick)
    );

    assign hz = bus.Hazard | (bus.Left & bus.Right);

    // A sequence state with a step outside 1..LAMPS is as bad as an unused code.
    always_comb begin
        legal = state_encoding_legal(state_q);
        if (state_q == LSEQ || state_q == RSEQ) begin
            legal = (step_q != '0) && (step_q <= STEP_MAX);
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        if (!legal) begin
            state_d = IDLE;
            step_d  = '0;
        end else if (tick) begin
            step_d = '0;
            if (hz) begin
                state_d = (state_q == HAZ_ON) ? HAZ_OFF : HAZ_ON;
            end else begin
                state_d = IDLE;
                case (state_q)
                    IDLE: begin
                        if (bus.Left) begin
                            state_d = LSEQ;
                            step_d  = SW'(1);
                        end else if (bus.Right) begin
                            state_d = RSEQ;
                            step_d  = SW'(1);
                        end
                    end
                    LSEQ: begin
                        if (bus.Left && !bus.Right && step_q < STEP_MAX) begin
                            state_d = LSEQ;
                            step_d  = step_q + SW'(1);
                        end
                    end
                    RSEQ: begin
                        if (bus.Right && !bus.Left && step_q < STEP_MAX) begin
                            state_d = RSEQ;
                            step_d  = step_q + SW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= IDLE;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        bar = '0;
        for (int i = 0; i < LAMPS; i++) begin
            bar[i] = (i < int'(step_q));
        end
    end

    // Lamps are forced dark while reset is held so Brake cannot leak through.
    always_comb begin
        l_dec = '0;
        r_dec = '0;
        case (state_q)
            IDLE: begin
                if (bus.Brake) begin
                    l_dec = '1;
                    r_dec = '1;
                end
            end
            LSEQ: begin
                l_dec = bar;
                if (bus.Brake) r_dec = '1;
            end
            RSEQ: begin
                r_dec = bar;
                if (bus.Brake) l_dec = '1;
            end
            HAZ_ON: begin
                l_dec = '1;
                r_dec = '1;
            end
            default: ;
        endcase
        if (Rst || !legal) begin
            l_dec = '0;
            r_dec = '0;
        end
    end

    assign bus.L = l_dec;
    assign bus.R = r_dec;

endmodule
`default_nettype wire
